// File: rtl/uart_rcv_if.sv
// Byte stream from the UART receiver to its consumer (valid/ready).
// master = receiver side, slave = consumer side.
interface uart_rcv_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rcv.sv
// UART receiver: recovers 8N1 frames at WAIT_TIME clocks per bit and hands bytes out
// over valid/ready, with sticky framing and overrun flags.
module uart_rcv #(
  parameter int WAIT_TIME = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_in,
  input  logic       err_clr,
  uart_rcv_if.master stream,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);
  localparam int HALF = WAIT_TIME / 2;
  localparam logic [7:0] HALF_M1 = 8'(HALF - 1);
  localparam logic [7:0] WAIT_M1 = 8'(WAIT_TIME - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t     state_reg;
  logic       sync1_reg;
  logic       rx_s_reg;
  logic       rx_prev_reg;
  logic [7:0] cnt_reg;
  logic [2:0] idx_reg;
  logic [7:0] shift_reg;
  logic [7:0] data_reg;
  logic       valid_reg;
  logic       busy_reg;
  logic       frame_err_reg;
  logic       overrun_reg;
  logic       byte_done;

  // A high line at any point of the stop window completes the byte, so a
  // one-cycle stop from a back-to-back transmitter is accepted.
  assign byte_done = (state_reg == STOP) && rx_s_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sync1_reg     <= 1'b1;
      rx_s_reg      <= 1'b1;
      rx_prev_reg   <= 1'b1;
      cnt_reg       <= 8'd0;
      idx_reg       <= 3'd0;
      shift_reg     <= 8'd0;
      data_reg      <= 8'd0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      sync1_reg   <= rxd_in;
      rx_s_reg    <= sync1_reg;
      rx_prev_reg <= rx_s_reg;

      // Clear first so that an error raised in the same cycle still sticks.
      if (err_clr) begin
        frame_err_reg <= 1'b0;
        overrun_reg   <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (rx_prev_reg && !rx_s_reg) begin
            state_reg <= START;
            cnt_reg   <= 8'd0;
            busy_reg  <= 1'b1;
          end
        end
        START: begin
          if (cnt_reg == HALF_M1) begin
            cnt_reg <= 8'd0;
            if (rx_s_reg) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= DATA;
              idx_reg   <= 3'd0;
            end
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DATA: begin
          if (cnt_reg == WAIT_M1) begin
            shift_reg[idx_reg] <= rx_s_reg;
            cnt_reg            <= 8'd0;
            if (idx_reg == 3'd7) begin
              state_reg <= STOP;
              idx_reg   <= 3'd0;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        STOP: begin
          if (rx_s_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (cnt_reg == WAIT_M1) begin
            state_reg     <= BREAK;
            frame_err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        BREAK: begin
          if (rx_s_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      if (byte_done) begin
        if (!valid_reg || stream.out_ready) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && stream.out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign stream.out_data  = data_reg;
  assign stream.out_valid = valid_reg;
  assign busy             = busy_reg;
  assign frame_err        = frame_err_reg;
  assign overrun          = overrun_reg;
endmodule
